rename_free_list: RTL
=====================

Name: rename_free_list

Overview:
- Rename-side free list of physical registers: hands unallocated physical register numbers to rename and takes back the old physical register freed by each retiring instruction from the commit stage.
- Sits between rename and commit as the receiving end of the commit-to-rename retirement interface.
- Implemented as a ring holding exactly DEPTH entries, with a speculative head and a committed head. A misprediction restores the speculative head to the committed head, which reclaims every register allocated on the wrong path.

Parameters:
- NUM_PHYS_REG, 64, number of physical registers.
- NUM_ARCH_REG, 8, number of architectural registers. Physical registers 0..NUM_ARCH_REG-1 are the reset mapping.
- DEPTH, NUM_PHYS_REG-NUM_ARCH_REG (56), ring entries. Need not be a power of two.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- alloc_v_o  out  1  a free physical register is available.
- alloc_phys_o  out  $clog2(NUM_PHYS_REG)  register offered; valid when alloc_v_o=1.
- alloc_yumi_i  in  1  rename consumes alloc_phys_o this cycle.
- rob_rename_valid_i  in  1  one instruction retires this cycle.
- rob_commit_has_dest_i  in  1  the retiring instruction wrote a destination register.
- rob_commit_free_phys_i  in  $clog2(NUM_PHYS_REG)  old physical register to free.
- rob_mispredict_i  in  1  flush all speculative allocations.
- free_count_o  out  $clog2(DEPTH+1)  number of registers currently allocatable.

Behaviour:
- State:
  - mem[0..DEPTH-1], each $clog2(NUM_PHYS_REG) bits.
  - spec_head, commit_head: ring indices; increment wraps explicitly from DEPTH-1 to 0.
  - inflight: 0..DEPTH, count of registers allocated but not yet retired.
- Invariant: the committed view always holds DEPTH entries, so the slot at commit_head is also the write slot for freed registers. No separate tail pointer.
- Reset (asynchronous, while reset_i=0):
  - mem[i]=NUM_ARCH_REG+i; spec_head=0; commit_head=0; inflight=0.
  - Outputs: alloc_v_o=1, alloc_phys_o=NUM_ARCH_REG, free_count_o=DEPTH.
- Outputs are combinational from registered state only; no input-to-output paths.
  - alloc_v_o = (inflight != DEPTH).
  - alloc_phys_o = mem[spec_head] (show-ahead read).
  - free_count_o = DEPTH - inflight.
- Allocate (alloc = alloc_yumi_i & alloc_v_o & ~rob_mispredict_i):
  - spec_head++; inflight+1.
  - Zero-latency handoff: the value is taken in the same cycle as yumi.
  - alloc_yumi_i while alloc_v_o=0 is ignored, and a simulation assertion fires.
- Retire (ret = rob_rename_valid_i & rob_commit_has_dest_i):
  - mem[commit_head] <= rob_commit_free_phys_i; commit_head++; inflight-1.
  - rob_rename_valid_i with rob_commit_has_dest_i=0 changes nothing.
  - ret while inflight=0 is ignored, and an assertion fires.
- Simultaneous allocate and retire: inflight_next = inflight + alloc - ret. Both pointer updates apply.
  - No slot conflict: the alloc slot equals the retire slot only when inflight=0, and ret is illegal then.
- The freed register becomes allocatable only once spec_head reaches its slot. It is never bypassed.
- Mispredict (rob_mispredict_i=1):
  - A same-cycle retire is applied first.
  - Then spec_head <= commit_head_next and inflight <= 0.
  - A same-cycle yumi is discarded: no allocation and no state change from it. Rename must retry the next cycle.
- Full: inflight=DEPTH gives alloc_v_o=0. Rename stalls until a retire or a mispredict.
- Reset mid-operation: immediate return to the reset contents. Any in-flight yumi or retire is lost.

Test Plan:
- Reset: hold reset_i=0, then release. Expect alloc_v_o=1, alloc_phys_o=8 and free_count_o=56 both during and after reset.
- Three back-to-back yumi: expect rename to receive 8, 9, 10. Next cycle expect alloc_phys_o=11 and free_count_o=53.
- Exhaust the list: 56 consecutive yumi. Expect registers 8..63 in order, then alloc_v_o=0 and free_count_o=0. A further yumi changes nothing and the assertion fires.
- Retire after exhaustion: retire with dest and free_phys=3. Next cycle expect alloc_v_o=1 and free_count_o=1. Allocate, then expect alloc_phys_o=3 (spec_head wrapped to slot 0).
- Mispredict recovery: from reset, allocate 8..12 (5 allocations), then retire with dest twice, freeing 1 and 2. Assert rob_mispredict_i together with yumi. Expect free_count_o=56 and alloc_phys_o=10 (slot 2). Expect mem[0]=1 and mem[1]=2.
- Simultaneous alloc, retire and mispredict: inflight=4 with spec_head=4. Apply alloc, a retire freeing 5, and mispredict in the same cycle. Expect commit_head=1, spec_head=1, inflight=0, mem[0]=5 and alloc_phys_o=9.

Source files
------------

// File: rtl/rename_free_list.sv
// Rename-side free list of physical registers: a DEPTH-entry ring with a speculative
// head for allocation and a committed head that also serves as the write slot for freed registers.
module rename_free_list #(
    parameter int unsigned NUM_PHYS_REG = 64,
    parameter int unsigned NUM_ARCH_REG = 8,
    parameter int unsigned DEPTH        = NUM_PHYS_REG - NUM_ARCH_REG
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    output logic                            alloc_v_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] alloc_phys_o,
    input  logic                            alloc_yumi_i,
    input  logic                            rob_rename_valid_i,
    input  logic                            rob_commit_has_dest_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] rob_commit_free_phys_i,
    input  logic                            rob_mispredict_i,
    output logic [$clog2(DEPTH+1)-1:0]      free_count_o
);

    localparam int unsigned PW = $clog2(NUM_PHYS_REG);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // Ring index increment; DEPTH need not be a power of two.
    function automatic logic [IW-1:0] ring_inc(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IW'(1);
    endfunction

    logic [PW-1:0] mem_q [DEPTH];
    logic [IW-1:0] spec_head_q,   spec_head_d;
    logic [IW-1:0] commit_head_q, commit_head_d;
    logic [CW-1:0] inflight_q,    inflight_d;

    logic alloc_c;
    logic ret_c;

    assign alloc_v_o    = (inflight_q != DEPTH_CNT);
    assign alloc_phys_o = mem_q[spec_head_q];
    assign free_count_o = DEPTH_CNT - inflight_q;

    // Illegal requests (yumi when empty, retire with nothing in flight) are dropped.
    assign alloc_c = alloc_yumi_i & alloc_v_o & ~rob_mispredict_i;
    assign ret_c   = rob_rename_valid_i & rob_commit_has_dest_i & (inflight_q != '0);

    // Retire lands first; a mispredict then snaps the speculative head onto the updated commit head.
    always_comb begin
        commit_head_d = commit_head_q;
        spec_head_d   = spec_head_q;
        inflight_d    = inflight_q;

        if (ret_c) begin
            commit_head_d = ring_inc(commit_head_q);
        end

        if (rob_mispredict_i) begin
            spec_head_d = commit_head_d;
            inflight_d  = '0;
        end else begin
            if (alloc_c) begin
                spec_head_d = ring_inc(spec_head_q);
            end
            inflight_d = inflight_q + CW'(alloc_c) - CW'(ret_c);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            spec_head_q   <= '0;
            commit_head_q <= '0;
            inflight_q    <= '0;
        end else begin
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            inflight_q    <= inflight_d;
        end
    end

    // The slot at commit_head is free to overwrite: it was allocated and has now retired.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= PW'(NUM_ARCH_REG + i);
            end
        end else if (ret_c) begin
            mem_q[commit_head_q] <= rob_commit_free_phys_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (!(alloc_yumi_i && !alloc_v_o))
                else $warning("rename_free_list: yumi with no free register, ignored");
            assert (!(rob_rename_valid_i && rob_commit_has_dest_i && (inflight_q == '0)))
                else $warning("rename_free_list: retire with nothing in flight, ignored");
        end
    end

endmodule
